bmem_arbiter: RTL

Shares the single banked-memory port (`bmem_*`) between the instruction cache and the data cache in `cpu`. It converts 256-bit cache-line requests into 64-bit memory bursts. Write bursts go out as four consecutive beats. Read requests are single-cycle, and their four returned beats are routed back to the owning cache by matching `bmem_raddr`. It sits between the two cache miss ports and the top-level `bmem_*` pins.

---
 rtl/bmem_pkg.sv | 18 +
 rtl/bmem_arbiter_if.sv | 18 +
 rtl/bmem_line_assembler.sv | 84 ++++++++
 rtl/bmem_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bmem_pkg.sv
// Shared widths, types and helpers for the cache-to-banked-memory arbiter.
package bmem_pkg;
  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int NBEATS    = LINE_BITS / BEAT_BITS;
  localparam int CNT_W     = $clog2(NBEATS);
  localparam logic [31:0] LINE_MASK = 32'h0000_001F;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [BEAT_BITS-1:0] beat_t;

  typedef enum logic {BM_IDLE, BM_WRITE} bm_state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~LINE_MASK;
  endfunction
endpackage

// File: rtl/bmem_arbiter_if.sv
// Banked-memory port: request strobes and write beat out, read beats back in.
interface bmem_arbiter_if
  import bmem_pkg::*;
;
  logic [31:0] addr;
  logic        read;
  logic        write;
  beat_t       wdata;
  logic        ready;
  logic [31:0] raddr;
  beat_t       rdata;
  logic        rvalid;

  modport master (output addr, read, write, wdata,
                  input  ready, raddr, rdata, rvalid);
  modport slave  (input  addr, read, write, wdata,
                  output ready, raddr, rdata, rvalid);
endinterface

// File: rtl/bmem_line_assembler.sv
// Per-port miss tracker: busy flag, latched line address, beat counter,
// line assembly and the registered completion pulse.
module bmem_line_assembler
  import bmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_issue,
  input  logic        wr_issue,
  input  logic        wr_done,
  input  logic [31:0] issue_addr,
  input  logic        beat_valid,
  input  beat_t       beat_data,
  output logic        busy,
  output logic        rd_pending,
  output logic [31:0] addr,
  output line_t       rdata,
  output logic        resp
);
  logic             busy_q, busy_d;
  logic             rd_q, rd_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  line_t            line_q, line_d;
  line_t            rdata_q, rdata_d;
  logic             resp_q, resp_d;

  always_comb begin
    busy_d  = busy_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    if (rd_issue || wr_issue) begin
      busy_d = 1'b1;
      rd_d   = rd_issue;
      addr_d = issue_addr;
      cnt_d  = '0;
    end
    if (beat_valid) begin
      line_d[int'(cnt_q)*BEAT_BITS +: BEAT_BITS] = beat_data;
      cnt_d = cnt_q + CNT_W'(1);
      // rdata only changes once the whole line is in, so it holds between fills
      if (cnt_q == CNT_W'(NBEATS-1)) begin
        rdata_d = line_d;
        resp_d  = 1'b1;
        busy_d  = 1'b0;
        rd_d    = 1'b0;
      end
    end
    if (wr_done) begin
      resp_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign busy       = busy_q;
  assign rd_pending = busy_q & rd_q;
  assign addr       = addr_q;
  assign rdata      = rdata_q;
  assign resp       = resp_q;
endmodule

// File: rtl/bmem_arbiter.sv
// Shares one banked-memory port between I-cache and D-cache: round-robin
// issue, 4-beat write bursts, read beats steered back by returned address.
module bmem_arbiter
  import bmem_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    i_addr,
  input  logic           i_read,
  output line_t          i_rdata,
  output logic           i_resp,
  input  logic [31:0]    d_addr,
  input  logic           d_read,
  input  logic           d_write,
  input  line_t          d_wdata,
  output line_t          d_rdata,
  output logic           d_resp,
  bmem_arbiter_if.master bmem
);
  bm_state_t        state_q, state_d;
  port_t            rr_q, rr_d;
  logic [CNT_W-1:0] wbeat_q, wbeat_d;
  logic             i_older_q, i_older_d;
  logic [31:0]      baddr_q, baddr_d;
  logic             bread_q, bread_d;
  logic             bwrite_q, bwrite_d;
  beat_t            bwdata_q, bwdata_d;

  logic        i_busy, d_busy, i_rdpend, d_rdpend;
  logic [31:0] i_lat, d_lat;
  logic        i_rd_issue, d_rd_issue, d_wr_issue, d_wr_done;
  logic        i_new, d_new, i_match, d_match, i_beat, d_beat;

  // A request still held during its resp cycle must not count as new
  assign i_new = i_read & ~i_busy & ~i_resp;
  assign d_new = (d_read | d_write) & ~d_busy & ~d_resp;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    wbeat_d    = wbeat_q;
    i_older_d  = i_older_q;
    baddr_d    = baddr_q;
    bread_d    = 1'b0;
    bwrite_d   = 1'b0;
    bwdata_d   = bwdata_q;
    i_rd_issue = 1'b0;
    d_rd_issue = 1'b0;
    d_wr_issue = 1'b0;
    d_wr_done  = 1'b0;
    case (state_q)
      BM_IDLE: begin
        if (bmem.ready && (i_new || d_new)) begin
          if (d_new && (rr_q == PORT_D || !i_new)) begin
            rr_d    = PORT_I;
            baddr_d = line_align(d_addr);
            if (d_write) begin
              bwrite_d   = 1'b1;
              bwdata_d   = d_wdata[BEAT_BITS-1:0];
              wbeat_d    = CNT_W'(1);
              d_wr_issue = 1'b1;
              state_d    = BM_WRITE;
            end else begin
              bread_d    = 1'b1;
              d_rd_issue = 1'b1;
              i_older_d  = 1'b1;
            end
          end else begin
            rr_d       = PORT_D;
            baddr_d    = line_align(i_addr);
            bread_d    = 1'b1;
            i_rd_issue = 1'b1;
            i_older_d  = 1'b0;
          end
        end
      end
      BM_WRITE: begin
        // wbeat wraps to 0 after beat 3 went out; that cycle only raises d_resp
        if (wbeat_q == '0) begin
          d_wr_done = 1'b1;
          state_d   = BM_IDLE;
        end else begin
          bwrite_d = 1'b1;
          bwdata_d = d_wdata[int'(wbeat_q)*BEAT_BITS +: BEAT_BITS];
          wbeat_d  = wbeat_q + CNT_W'(1);
        end
      end
      default: state_d = BM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BM_IDLE;
      rr_q      <= PORT_D;
      wbeat_q   <= '0;
      i_older_q <= 1'b0;
      baddr_q   <= '0;
      bread_q   <= 1'b0;
      bwrite_q  <= 1'b0;
      bwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      wbeat_q   <= wbeat_d;
      i_older_q <= i_older_d;
      baddr_q   <= baddr_d;
      bread_q   <= bread_d;
      bwrite_q  <= bwrite_d;
      bwdata_q  <= bwdata_d;
    end
  end

  assign bmem.addr  = baddr_q;
  assign bmem.read  = bread_q;
  assign bmem.write = bwrite_q;
  assign bmem.wdata = bwdata_q;

  // Same-line reads on both ports: the earlier-issued port takes the beats first
  assign i_match = i_rdpend && (line_align(bmem.raddr) == i_lat);
  assign d_match = d_rdpend && (line_align(bmem.raddr) == d_lat);
  assign i_beat  = bmem.rvalid && i_match && (!d_match || i_older_q);
  assign d_beat  = bmem.rvalid && d_match && (!i_match || !i_older_q);

  bmem_line_assembler u_i_asm (
    .clk        (clk),
    .rst        (rst),
    .rd_issue   (i_rd_issue),
    .wr_issue   (1'b0),
    .wr_done    (1'b0),
    .issue_addr (line_align(i_addr)),
    .beat_valid (i_beat),
    .beat_data  (bmem.rdata),
    .busy       (i_busy),
    .rd_pending (i_rdpend),
    .addr       (i_lat),
    .rdata      (i_rdata),
    .resp       (i_resp)
  );

  bmem_line_assembler u_d_asm (
    .clk        (clk),
    .rst        (rst),
    .rd_issue   (d_rd_issue),
    .wr_issue   (d_wr_issue),
    .wr_done    (d_wr_done),
    .issue_addr (line_align(d_addr)),
    .beat_valid (d_beat),
    .beat_data  (bmem.rdata),
    .busy       (d_busy),
    .rd_pending (d_rdpend),
    .addr       (d_lat),
    .rdata      (d_rdata),
    .resp       (d_resp)
  );
endmodule
